// File: rtl/wb_stream_reader_cfg_mc.sv
// Wishbone B4 classic configuration and status block for NUM_CH stream reader DMA engines.
// Ports:
//   wb_clk_i, wb_rst_ni             : clock, synchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i : Wishbone slave request ([7:5] channel, [4:2] register)
//   wb_dat_o/ack_o/err_o            : registered read data, acknowledge, bad-channel error
//   busy, tx_cnt                    : per-channel engine status
//   enable, circular, start_adr, buf_size, burst_size : per-channel configuration
//   irq_ch, irq                     : per-channel masked pending, combined interrupt
module wb_stream_reader_cfg_mc #(
  parameter int unsigned WB_AW          = 32,
  parameter int unsigned WB_DW          = 32,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned BUF_SIZE_RST   = 100,
  parameter int unsigned BURST_SIZE_RST = 2,
  parameter int unsigned TX_CNT_SHIFT   = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [7:0]               wb_adr_i,
  input  logic [WB_DW-1:0]         wb_dat_i,
  input  logic [WB_DW/8-1:0]       wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [WB_DW-1:0]         wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic [NUM_CH-1:0]        busy,
  input  logic [NUM_CH*WB_DW-1:0]  tx_cnt,
  output logic [NUM_CH-1:0]        enable,
  output logic [NUM_CH-1:0]        circular,
  output logic [NUM_CH*WB_AW-1:0]  start_adr,
  output logic [NUM_CH*WB_AW-1:0]  buf_size,
  output logic [NUM_CH*WB_AW-1:0]  burst_size,
  output logic [NUM_CH-1:0]        irq_ch,
  output logic                     irq
);

  localparam int unsigned SW = WB_DW / 8;

  logic [NUM_CH-1:0] r_enable, r_circular, r_pending, r_int_en, r_busy, r_irq_ch;
  logic [WB_AW-1:0]  r_start_adr  [NUM_CH];
  logic [WB_AW-1:0]  r_buf_size   [NUM_CH];
  logic [WB_AW-1:0]  r_burst_size [NUM_CH];
  logic [WB_DW-1:0]  r_dat;
  logic              r_ack, r_err, r_irq;

  logic              w_req, w_bad;
  logic [2:0]        w_ch, w_reg;
  logic [NUM_CH-1:0] w_wr, w_ctrl_wr, w_start, w_abort, w_w1c, w_fall;
  logic [WB_DW-1:0]  w_rdata;
  logic              w_unused;

  // Request decode: a new request is only seen once the previous ack/err has retired
  assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_ch     = wb_adr_i[7:5];
  assign w_reg    = wb_adr_i[4:2];
  assign w_bad    = 32'(w_ch) >= NUM_CH;
  assign w_fall   = r_busy & ~busy;
  assign w_unused = ^wb_adr_i[1:0];

  // Per-channel write strobes; CTRL fields only act when byte lane 0 is selected
  always_comb begin
    w_wr      = '0;
    w_ctrl_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr[i]      = w_req & ~w_bad & wb_we_i & (w_ch == 3'(i));
      w_ctrl_wr[i] = w_wr[i] & (w_reg == 3'd0) & wb_sel_i[0];
    end
    w_start = w_ctrl_wr & {NUM_CH{wb_dat_i[0]}};
    w_w1c   = w_ctrl_wr & {NUM_CH{wb_dat_i[1]}};
    w_abort = w_ctrl_wr & {NUM_CH{wb_dat_i[3]}};
  end

  // Byte-lane merge into an address-type register; bits above WB_DW are cleared
  function automatic logic [WB_AW-1:0] f_merge(input logic [WB_AW-1:0] old,
                                                 input logic [WB_DW-1:0] dat,
                                                 input logic [SW-1:0]    sel);
    logic [WB_DW-1:0] v;
    v = WB_DW'(old);
    for (int unsigned b = 0; b < SW; b++)
      if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
    return WB_AW'(v);
  endfunction

  // Read mux; an out-of-range channel matches nothing and returns zero
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_ch == 3'(i)) begin
        case (w_reg)
          3'd0:    w_rdata = WB_DW'({r_enable[i], r_circular[i], r_pending[i], busy[i]});
          3'd1:    w_rdata = WB_DW'(r_start_adr[i]);
          3'd2:    w_rdata = WB_DW'(r_buf_size[i]);
          3'd3:    w_rdata = WB_DW'(r_burst_size[i]);
          3'd4:    w_rdata = WB_DW'(tx_cnt[i*WB_DW +: WB_DW] << TX_CNT_SHIFT);
          3'd5:    w_rdata = WB_DW'(r_int_en[i]);
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_enable   <= '0;
      r_circular <= '0;
      r_pending  <= '0;
      r_int_en   <= '1;
      r_busy     <= '0;
      r_irq_ch   <= '0;
      r_irq      <= 1'b0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_start_adr[i]  <= '0;
        r_buf_size[i]   <= WB_AW'(BUF_SIZE_RST);
        r_burst_size[i] <= WB_AW'(BURST_SIZE_RST);
      end
    end else begin
      r_ack    <= w_req & ~w_bad;
      r_err    <= w_req & w_bad;
      if (w_req) r_dat <= w_rdata;
      r_busy   <= busy;
      r_irq_ch <= r_pending & r_int_en;
      r_irq    <= |r_irq_ch;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // Later assignments win: completion < start < abort; W1C < completion set
        if (w_fall[i] & ~r_circular[i]) r_enable[i] <= 1'b0;
        if (w_start[i])                 r_enable[i] <= 1'b1;
        if (w_abort[i])                 r_enable[i] <= 1'b0;
        if (w_w1c[i])                   r_pending[i] <= 1'b0;
        if (w_fall[i])                  r_pending[i] <= 1'b1;
        if (w_ctrl_wr[i])               r_circular[i] <= wb_dat_i[2];
        if (w_wr[i] && (w_reg == 3'd5) && wb_sel_i[0]) r_int_en[i] <= wb_dat_i[0];
        // Buffer configuration is locked while the engine is busy
        if (w_wr[i] && !busy[i]) begin
          case (w_reg)
            3'd1:    r_start_adr[i]  <= f_merge(r_start_adr[i],  wb_dat_i, wb_sel_i);
            3'd2:    r_buf_size[i]   <= f_merge(r_buf_size[i],   wb_dat_i, wb_sel_i);
            3'd3:    r_burst_size[i] <= f_merge(r_burst_size[i], wb_dat_i, wb_sel_i);
            default: ;
          endcase
        end
      end
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign enable   = r_enable;
  assign circular = r_circular;
  assign irq_ch   = r_irq_ch;
  assign irq      = r_irq;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign start_adr[g*WB_AW +: WB_AW]  = r_start_adr[g];
    assign buf_size[g*WB_AW +: WB_AW]   = r_buf_size[g];
    assign burst_size[g*WB_AW +: WB_AW] = r_burst_size[g];
  end

endmodule

// File: tb/tb_wb_stream_reader_cfg_mc.sv
// Bench for wb_stream_reader_cfg_mc: directed test-plan steps then randomized accesses,
// checked against an edge-level reference model of the register block.
module tb_wb_stream_reader_cfg_mc;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   adr;
  logic [31:0]  dat_i;
  logic [3:0]   sel;
  logic         we, cyc, stb;
  logic [31:0]  dat_o;
  logic         ack, err;
  logic [3:0]   busy;
  logic [127:0] tx_cnt;
  logic [3:0]   enable, circular, irq_ch;
  logic [127:0] start_adr, buf_size, burst_size;
  logic         irq;

  always #5 clk = ~clk;

  wb_stream_reader_cfg_mc dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .busy(busy), .tx_cnt(tx_cnt), .enable(enable), .circular(circular),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .irq_ch(irq_ch), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_sa [8];
  logic [31:0] m_bs [8];
  logic [31:0] m_bu [8];
  logic [7:0]  m_en, m_ci, m_pe, m_ie, m_bprev, m_irqch;
  logic        m_irq;
  // Pending request seen at the next edge
  logic        q_act, q_we;
  logic [2:0]  q_ch, q_reg;
  logic [31:0] q_dat;
  logic [3:0]  q_sel;
  logic [31:0] exp_rd;
  logic        exp_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sa[i] = 32'd0; m_bs[i] = 32'd100; m_bu[i] = 32'd2;
    end
    m_en = 8'd0; m_ci = 8'd0; m_pe = 8'd0; m_ie = 8'hFF;
    m_bprev = 8'd0; m_irqch = 8'd0; m_irq = 1'b0;
  endtask

  // What one clock edge does to the register block, given current inputs
  task automatic model_edge();
    logic [7:0]  bz, fall, start, abort, w1c, old_ci;
    logic [31:0] v, tx;
    bz     = 8'(busy);
    fall   = m_bprev & ~bz;
    old_ci = m_ci;
    start = 8'd0; abort = 8'd0; w1c = 8'd0;
    m_irq   = |m_irqch[NCH-1:0];
    m_irqch = m_pe & m_ie & 8'h0F;
    if (q_act) begin
      exp_err = (int'(q_ch) >= NCH);
      exp_rd  = 32'd0;
      if (!exp_err) begin
        tx = tx_cnt[q_ch*32 +: 32];
        case (q_reg)
          3'd0: exp_rd = {28'd0, m_en[q_ch], m_ci[q_ch], m_pe[q_ch], bz[q_ch]};
          3'd1: exp_rd = m_sa[q_ch];
          3'd2: exp_rd = m_bs[q_ch];
          3'd3: exp_rd = m_bu[q_ch];
          3'd4: exp_rd = tx * 4;
          3'd5: exp_rd = {31'd0, m_ie[q_ch]};
          default: exp_rd = 32'd0;
        endcase
        if (q_we) begin
          if (q_reg == 3'd0 && q_sel[0]) begin
            start[q_ch] = q_dat[0]; w1c[q_ch] = q_dat[1]; abort[q_ch] = q_dat[3];
            m_ci[q_ch]  = q_dat[2];
          end
          if (q_reg >= 3'd1 && q_reg <= 3'd3 && !bz[q_ch]) begin
            v = (q_reg == 3'd1) ? m_sa[q_ch] : (q_reg == 3'd2) ? m_bs[q_ch] : m_bu[q_ch];
            for (int b = 0; b < 4; b++) if (q_sel[b]) v[8*b +: 8] = q_dat[8*b +: 8];
            if (q_reg == 3'd1) m_sa[q_ch] = v;
            else if (q_reg == 3'd2) m_bs[q_ch] = v;
            else m_bu[q_ch] = v;
          end
          if (q_reg == 3'd5 && q_sel[0]) m_ie[q_ch] = q_dat[0];
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (abort[i]) m_en[i] = 1'b0;
      else if (start[i]) m_en[i] = 1'b1;
      else if (fall[i] && !old_ci[i]) m_en[i] = 1'b0;
      if (fall[i]) m_pe[i] = 1'b1;
      else if (w1c[i]) m_pe[i] = 1'b0;
    end
    m_bprev = bz;
  endtask

  task automatic tick();
    if (rst_n) model_edge(); else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [2:0] ch, input logic [2:0] rg, input logic w,
                      input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
    adr = {ch, rg, 2'b00}; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    q_act = 1'b1; q_ch = ch; q_reg = rg; q_we = w; q_dat = d; q_sel = s;
    tick();
    q_act = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk($sformatf("ack ch%0d r%0d", ch, rg), 32'(ack), 32'(!exp_err));
    chk($sformatf("err ch%0d r%0d", ch, rg), 32'(err), 32'(exp_err));
    if (!w) chk($sformatf("rdata ch%0d r%0d", ch, rg), dat_o, exp_rd);
    rd = dat_o;
    tick();
    chk("ack_one_cycle", 32'({ack, err}), 32'd0);
  endtask

  task automatic check_outs();
    chk("enable", 32'(enable), 32'(m_en[3:0]));
    chk("circular", 32'(circular), 32'(m_ci[3:0]));
    chk("irq_ch", 32'(irq_ch), 32'(m_irqch[3:0]));
    chk("irq", 32'(irq), 32'(m_irq));
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("start_adr%0d", i), start_adr[i*32 +: 32], m_sa[i]);
      chk($sformatf("buf_size%0d", i), buf_size[i*32 +: 32], m_bs[i]);
      chk($sformatf("burst_size%0d", i), burst_size[i*32 +: 32], m_bu[i]);
    end
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0; adr = 8'd0; dat_i = 32'd0; sel = 4'd0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    busy = 4'd0; tx_cnt = 128'd0; q_act = 1'b0; q_we = 1'b0; q_ch = 3'd0; q_reg = 3'd0;
    q_dat = 32'd0; q_sel = 4'd0; exp_rd = 32'd0; exp_err = 1'b0;
    model_reset();
    #2;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_ack", 32'({ack, err}), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      xfer(3'(c), 3'd2, 1'b0, 32'd0, 4'hF, rd); chk("rst_buf_size", rd, 32'd100);
      xfer(3'(c), 3'd3, 1'b0, 32'd0, 4'hF, rd); chk("rst_burst_size", rd, 32'd2);
      xfer(3'(c), 3'd0, 1'b0, 32'd0, 4'hF, rd); chk("rst_ctrl", rd, 32'd0);
    end

    // Byte-lane masked start address on ch2
    xfer(3'd2, 3'd1, 1'b1, 32'h1000_0000, 4'hF, rd);
    xfer(3'd2, 3'd1, 1'b1, 32'h0000_00FF, 4'h1, rd);
    xfer(3'd2, 3'd1, 1'b0, 32'd0, 4'hF, rd);
    chk("ch2_start_adr", rd, 32'h1000_00FF);
    chk("ch2_start_adr_port", start_adr[64 +: 32], 32'h1000_00FF);
    chk("ch1_start_adr_port", start_adr[32 +: 32], 32'd0);
    check_outs();

    // ch1 single-shot completion and interrupt timing
    xfer(3'd1, 3'd0, 1'b1, 32'h1, 4'h1, rd);
    chk("ch1_start", 32'(enable[1]), 32'd1);
    busy[1] = 1'b1;
    repeat (10) tick();
    busy[1] = 1'b0;
    tick();
    chk("ch1_done_enable", 32'(enable[1]), 32'd0);
    chk("ch1_irq_ch_N", 32'(irq_ch[1]), 32'd0);
    tick();
    chk("ch1_irq_ch_N1", 32'(irq_ch[1]), 32'd1);
    chk("ch1_irq_N1", 32'(irq), 32'd0);
    tick();
    chk("ch1_irq_N2", 32'(irq), 32'd1);
    xfer(3'd1, 3'd0, 1'b0, 32'd0, 4'hF, rd);
    chk("ch1_ctrl_pending", rd, 32'h2);
    xfer(3'd1, 3'd0, 1'b1, 32'h2, 4'h1, rd);
    tick();
    chk("ch1_irq_cleared", 32'(irq), 32'd0);
    check_outs();

    // ch0 circular mode with interrupt masked
    xfer(3'd0, 3'd5, 1'b1, 32'h0, 4'h1, rd);
    xfer(3'd0, 3'd0, 1'b1, 32'h5, 4'h1, rd);
    chk("ch0_enable", 32'(enable[0]), 32'd1);
    chk("ch0_circular", 32'(circular[0]), 32'd1);
    busy[0] = 1'b1;
    repeat (5) tick();
    busy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ch0_irq_masked", 32'(irq), 32'd0);
    end
    chk("ch0_enable_kept", 32'(enable[0]), 32'd1);
    xfer(3'd0, 3'd0, 1'b0, 32'd0, 4'hF, rd);
    chk("ch0_ctrl", rd, 32'hE);

    // ch3 locked while busy, tx_cnt readback in bytes
    busy[3] = 1'b1;
    tick();
    xfer(3'd3, 3'd2, 1'b1, 32'h400, 4'hF, rd);
    xfer(3'd3, 3'd2, 1'b0, 32'd0, 4'hF, rd);
    chk("ch3_locked", rd, 32'd100);
    tx_cnt[96 +: 32] = 32'd25;
    xfer(3'd3, 3'd4, 1'b0, 32'd0, 4'hF, rd);
    chk("ch3_tx_cnt", rd, 32'd100);
    busy[3] = 1'b0;
    tick();
    xfer(3'd3, 3'd0, 1'b1, 32'h2, 4'h1, rd);
    tick(); tick();
    check_outs();

    // Bad channel and start+abort
    xfer(3'd5, 3'd2, 1'b1, 32'h55, 4'hF, rd);
    xfer(3'd5, 3'd2, 1'b0, 32'd0, 4'hF, rd);
    chk("bad_rdata", rd, 32'd0);
    xfer(3'd1, 3'd2, 1'b0, 32'd0, 4'hF, rd);
    chk("bad_no_alias", rd, 32'd100);
    xfer(3'd2, 3'd0, 1'b1, 32'h1, 4'h1, rd);
    chk("ch2_start", 32'(enable[2]), 32'd1);
    xfer(3'd2, 3'd0, 1'b1, 32'h9, 4'h1, rd);
    chk("ch2_start_abort", 32'(enable[2]), 32'd0);

    // Start and W1C at the same edge as a completion: start and set both win
    xfer(3'd1, 3'd0, 1'b1, 32'h1, 4'h1, rd);
    busy[1] = 1'b1;
    repeat (3) tick();
    busy[1] = 1'b0;
    xfer(3'd1, 3'd0, 1'b1, 32'h3, 4'h1, rd);
    chk("ch1_start_wins", 32'(enable[1]), 32'd1);
    xfer(3'd1, 3'd0, 1'b0, 32'd0, 4'hF, rd);
    chk("ch1_set_wins", rd, 32'hA);
    xfer(3'd1, 3'd0, 1'b1, 32'hA, 4'h1, rd);
    tick();
    check_outs();

    // Randomized accesses against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) busy = 4'($urandom);
      tx_cnt = {$urandom, $urandom, $urandom, $urandom};
      xfer(3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom, 4'($urandom), rd);
      tick();
      check_outs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
